// File: rtl/unidade_controle_jogada_pkg.sv
// Shared definitions for the sequence-memory game control unit: state codes
// (also used by the hex display decoder) and the Moore output bundle.
package unidade_controle_jogada_pkg;

  // State codes are fixed because db_estado drives the hex display directly.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_contador;
    logic conta_contador;
    logic zera_registrador;
    logic registra;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  localparam saidas_t SAIDAS_NULAS = '0;

  // Moore decode: every output is a pure function of the current state.
  function automatic saidas_t decodifica_saidas(input estado_t estado);
    saidas_t s;
    s = SAIDAS_NULAS;
    case (estado)
      PREPARACAO: begin
        s.zera_contador    = 1'b1;
        s.zera_registrador = 1'b1;
      end
      REGISTRA:    s.registra       = 1'b1;
      PROXIMO:     s.conta_contador = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = SAIDAS_NULAS;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogada_contador_timeout.sv
// Saturating per-jogada timeout counter: counts 0..M-1 while enabled and
// flags the terminal count; it never wraps.
module contador_timeout #(
  parameter int M  = 5000,
  localparam int TW = $clog2(M)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          zera,
  input  logic          conta,
  output logic [TW-1:0] q,
  output logic          fim
);

  assign fim = (q == TW'(M - 1));

  // NOTE: state is assigned with <= so every flop samples pre-edge values;
  // the reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta && !fim) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle_jogada.sv
// Control FSM for the sequence-memory game: start, clear datapath, then per
// address wait for a jogada, latch chaves, compare, and advance or finish.
module unidade_controle_jogada
  import unidade_controle_jogada_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registrador,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  estado_t       estado;
  estado_t       proximo;
  saidas_t       saidas;
  logic          tmo_zera;
  logic          tmo_conta;
  logic          tmo_fim;
  logic [TW-1:0] tmo_q;

  // The counter only runs in ESPERA, so each wait starts from zero and
  // reaches its terminal count on exactly the TIMEOUT_CYCLES-th cycle.
  assign tmo_conta = (estado == ESPERA);
  assign tmo_zera  = !tmo_conta;

  contador_timeout #(
    .M (TIMEOUT_CYCLES)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (tmo_zera),
    .conta (tmo_conta),
    .q     (tmo_q),
    .fim   (tmo_fim)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // NOTE: proximo gets a default before the case so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:    proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: proximo = ESPERA;
      // jogada beats the timeout when both arrive on the same cycle.
      ESPERA: begin
        if (jogada) begin
          proximo = REGISTRA;
        end else if (tmo_fim) begin
          proximo = FIM_TIMEOUT;
        end else begin
          proximo = ESPERA;
        end
      end
      REGISTRA: proximo = COMPARA;
      COMPARA: begin
        if (!igual) begin
          proximo = FIM_ERRO;
        end else if (fim_contagem) begin
          proximo = FIM_ACERTO;
        end else begin
          proximo = PROXIMO;
        end
      end
      PROXIMO:     proximo = ESPERA;
      FIM_ACERTO:  proximo = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:    proximo = iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT: proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:     proximo = INICIAL;
    endcase
  end

  always_comb begin
    saidas = decodifica_saidas(estado);
  end

  assign zera_contador    = saidas.zera_contador;
  assign conta_contador   = saidas.conta_contador;
  assign zera_registrador = saidas.zera_registrador;
  assign registra         = saidas.registra;
  assign pronto           = saidas.pronto;
  assign acertou          = saidas.acertou;
  assign errou            = saidas.errou;
  assign timeout          = saidas.timeout;
  assign db_estado        = estado;

  a_resultado_exclusivo: assert property (@(posedge clock)
    $onehot0({acertou, errou, timeout}));

  a_resultado_implica_pronto: assert property (@(posedge clock)
    (acertou || errou || timeout) |-> pronto);

  a_tmo_limpo_fora_espera: assert property (@(posedge clock)
    (!reset || estado != ESPERA) |=> (tmo_q == '0));

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// Directed self-checking bench for unidade_controle_jogada with an 8-cycle
// timeout: success, error, timeout, restart and mid-round reset scenarios.
module tb_unidade_controle_jogada;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim_contagem;
  logic       zera_contador;
  logic       conta_contador;
  logic       zera_registrador;
  logic       registra;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int checks;
  int errors;

  // Output order: zc, cc, zr, reg, pronto, acertou, errou, timeout.
  logic [7:0] outs;
  assign outs = {zera_contador, conta_contador, zera_registrador, registra,
                 pronto, acertou, errou, timeout};

  unidade_controle_jogada #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .jogada           (jogada),
    .igual            (igual),
    .fim_contagem     (fim_contagem),
    .zera_contador    (zera_contador),
    .conta_contador   (conta_contador),
    .zera_registrador (zera_registrador),
    .registra         (registra),
    .pronto           (pronto),
    .acertou          (acertou),
    .errou            (errou),
    .timeout          (timeout),
    .db_estado        (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++;
      $display("FAIL reset_estado got %h want 0", db_estado);
    end
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000000", outs);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (db_estado !== 4'h0 || outs !== 8'h00) begin
      errors++;
      $display("FAIL inicial_hold estado %h outs %b want 0 / 00000000", db_estado, outs);
    end
  endtask

  task automatic test_acerto();
    int n_conta;
    n_conta = 0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1 || outs !== 8'b1010_0000) begin
      errors++;
      $display("FAIL acerto_prep estado %h outs %b want 1 / 10100000", db_estado, outs);
    end
    tick();
    checks++;
    if (db_estado !== 4'h2 || outs !== 8'h00) begin
      errors++;
      $display("FAIL acerto_espera estado %h outs %b want 2 / 00000000", db_estado, outs);
    end
    for (int i = 0; i < 4; i++) begin
      jogada       = 1'b1;
      igual        = 1'b1;
      fim_contagem = (i == 3);
      tick();
      jogada = 1'b0;
      checks++;
      if (db_estado !== 4'h4 || outs !== 8'b0001_0000) begin
        errors++;
        $display("FAIL acerto_registra_%0d estado %h outs %b want 4 / 00010000", i, db_estado, outs);
      end
      tick();
      if (conta_contador === 1'b1) n_conta++;
      tick();
      if (conta_contador === 1'b1) n_conta++;
      if (i < 3) begin
        checks++;
        if (db_estado !== 4'h6) begin
          errors++;
          $display("FAIL acerto_proximo_%0d got %h want 6", i, db_estado);
        end
        tick();
      end
    end
    fim_contagem = 1'b0;
    checks++;
    if (db_estado !== 4'hA || outs !== 8'b0000_1100) begin
      errors++;
      $display("FAIL acerto_fim estado %h outs %b want A / 00001100", db_estado, outs);
    end
    checks++;
    if (n_conta !== 3) begin
      errors++;
      $display("FAIL acerto_conta got %0d want 3", n_conta);
    end
    tick();
    checks++;
    if (db_estado !== 4'hA) begin
      errors++;
      $display("FAIL acerto_hold got %h want A", db_estado);
    end
  endtask

  task automatic test_erro();
    int n_conta;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1) begin
      errors++;
      $display("FAIL erro_restart_acerto got %h want 1", db_estado);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      jogada       = 1'b1;
      igual        = (i < 2);
      fim_contagem = (i == 2);
      tick();
      jogada = 1'b0;
      tick();
      tick();
      if (i < 2) tick();
    end
    checks++;
    if (db_estado !== 4'hE || outs !== 8'b0000_1010) begin
      errors++;
      $display("FAIL erro_fim estado %h outs %b want E / 00001010", db_estado, outs);
    end
    igual        = 1'b1;
    fim_contagem = 1'b0;
    n_conta      = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (conta_contador !== 1'b0 || db_estado !== 4'hE) n_conta++;
    end
    checks++;
    if (n_conta !== 0) begin
      errors++;
      $display("FAIL erro_hold bad cycles %0d want 0", n_conta);
    end
  endtask

  task automatic test_restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1 || outs !== 8'b1010_0000) begin
      errors++;
      $display("FAIL restart_prep estado %h outs %b want 1 / 10100000", db_estado, outs);
    end
    tick();
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL restart_espera got %h want 2", db_estado);
    end
  endtask

  // Entered in the first ESPERA cycle; 8 cycles without jogada must time out.
  task automatic wait_timeout(input string tag);
    int early;
    early = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (db_estado !== 4'h2) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL %s_espera left ESPERA early in %0d cycles", tag, early);
    end
    tick();
    checks++;
    if (db_estado !== 4'hD || outs !== 8'b0000_1001) begin
      errors++;
      $display("FAIL %s_fim estado %h outs %b want D / 00001001", tag, db_estado, outs);
    end
  endtask

  task automatic test_timeout();
    wait_timeout("timeout");
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    checks++;
    if (db_estado !== 4'h4) begin
      errors++;
      $display("FAIL timeout_jogada_wins got %h want 4", db_estado);
    end
    tick();
    checks++;
    if (db_estado !== 4'h5) begin
      errors++;
      $display("FAIL timeout_compara got %h want 5", db_estado);
    end
  endtask

  task automatic test_reset_mid();
    reset   = 1'b0;
    iniciar = 1'b1;
    tick();
    checks++;
    if (db_estado !== 4'h0 || outs !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset estado %h outs %b want 0 / 00000000", db_estado, outs);
    end
    reset = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1) begin
      errors++;
      $display("FAIL mid_reset_restart got %h want 1", db_estado);
    end
    tick();
    wait_timeout("mid_reset");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    iniciar      = 1'b0;
    jogada       = 1'b0;
    igual        = 1'b0;
    fim_contagem = 1'b0;
    #2;
    test_reset();
    test_acerto();
    test_erro();
    test_restart();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
